tune_sequencer: RTL and testbench
=================================

Name: tune_sequencer

Overview:
- Owns the receiver's tuning frequency and produces the NCO phase increment consumed by am_detector.
- Arbitrates two requesters: rotary-encoder step events and UART absolute-frequency commands.
- Clamps the frequency to a legal band and converts Hz to phase_inc with a sequential shift-add multiply.
- Publishes phase_inc with a one-cycle valid pulse. Sits inside controller on the fast clock domain.

Parameters:
- FS_HZ, 16_000_000, sample-clock frequency used for conversion.
- FREQ_W, 24, width of the frequency register in Hz.
- PINC_W, 27, width of phase_inc.
- K_FRAC, 20, fractional bits of the conversion constant.
- F_MIN, 100_000, lowest legal tuning frequency in Hz.
- F_MAX, 7_999_999, highest legal tuning frequency in Hz.
- F_INIT, 1_000_000, frequency loaded at reset.

Ports:
- aclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- enc_step  in  1  one-cycle pulse per encoder detent.
- enc_dir  in  1  1 = up, 0 = down; sampled with enc_step.
- step_sel  in  2  step size: 0 = 10 Hz, 1 = 100 Hz, 2 = 1 kHz, 3 = 10 kHz.
- set_valid  in  1  UART absolute-set request.
- set_freq  in  FREQ_W  requested frequency in Hz.
- set_ready  out  1  set request accepted when set_valid && set_ready.
- freq  out  FREQ_W  current committed frequency.
- busy  out  1  conversion in progress.
- phase_inc  out  PINC_W  NCO increment.
- phase_inc_valid  out  1  one-cycle pulse when phase_inc updates.

Behaviour:
- Interface: one clock, aclk. reset is asynchronous and active-high.
- Reset values: freq = F_INIT, phase_inc = 0, phase_inc_valid = 0, set_ready = 0, busy = 1, pend = 0, state = INIT.
- Constant: K = round(2^(PINC_W+K_FRAC) / FS_HZ) = 8_796_093, 24 bits.
- Conversion: phase_inc = (freq * K) >> K_FRAC, truncated. Product width is FREQ_W + 24.
- State machine:
  - INIT: load multiplier with freq, go to MULT. After reset the NCO is therefore configured without any request.
  - IDLE: set_ready = 1, busy = 0.
    - set_valid high: accept. freq <= clamp(set_freq). pend <= 0 (absolute set overrides pending detents). Go to MULT.
    - else pend != 0: freq <= clamp(freq + pend * step). pend <= 0. Go to MULT.
    - else stay in IDLE.
  - MULT: busy = 1, set_ready = 0. One multiplicand bit per cycle, FREQ_W cycles, then go to DONE.
  - DONE: register phase_inc and pulse phase_inc_valid for 1 cycle. Go to IDLE.
- Latency: the request is accepted in IDLE cycle t; phase_inc_valid is high in cycle t + FREQ_W + 2 (26).
- pend: signed 4-bit saturating detent accumulator, range -7..+7.
  - Incremented or decremented on every enc_step, in any state. Saturates at the limits; extra detents are dropped.
  - enc_step coinciding with an IDLE consume: the new detent is kept in pend (applied next pass).
- step is sampled at consume time, not per detent.
- Arithmetic: FREQ_W+2 signed. clamp(x) = F_MIN if x < F_MIN, F_MAX if x > F_MAX, else x.
  - Wrap-around is never allowed. Stepping down from F_MIN stays at F_MIN.
- Simultaneous set_valid and pend != 0: UART wins and pend is cleared.
- set_valid while busy: not accepted. The requester holds set_valid and set_freq until set_ready.
- A request whose clamped result equals the current freq still runs a full conversion and pulses phase_inc_valid.
- Reset mid-MULT: aborts immediately. Outputs return to reset values; INIT republishes F_INIT.

Optional Feature:
- Macro: TUNE_ROUND_EN.
- Defined: add 2^(K_FRAC-1) to the product before the shift (round to nearest).
- Undefined: truncate.
- Latency is unchanged in both cases.

Decomposition:
- Package tune_pkg holds:
  - FS_HZ, K_FRAC and K_CONST.
  - Step lookup table {10, 100, 1000, 10000}.
  - State enum {INIT, IDLE, MULT, DONE}.
  - Function clamp_freq.
- Sub-module shift_add_mult (sequential unsigned multiplier): ports start, a, b, busy, done, product. Instantiated once.

Test Plan:
- Reset release, no stimulus -> freq = 1_000_000. phase_inc_valid pulses once with phase_inc = 8_388_607 (8_388_608 with TUNE_ROUND_EN).
- step_sel = 2, three enc_step up pulses while IDLE -> freq = 1_003_000. Exactly one or two valid pulses; the final phase_inc matches the formula.
- set_freq = 7_999_000, then step_sel = 3 with one up step -> freq clamps to 7_999_999. Down steps from F_MIN leave freq = 100_000.
- set_valid and enc_step in the same IDLE cycle with set_freq = 2_000_000 -> freq = 2_000_000, the step is applied afterwards (2_000_000 ± step), and no earlier pend survives.
- Ten enc_step up pulses during MULT -> pend saturates at 7. After DONE, freq increases by 7 × step.
- Assert reset in cycle 10 of MULT -> phase_inc = 0 and valid = 0 immediately. After release, phase_inc for F_INIT arrives 26 cycles later. set_valid held while busy -> accepted only once set_ready = 1.

Source files
------------

// File: rtl/tune_pkg.sv
// tune_pkg: shared constants, state encoding and helpers for the tuning sequencer.
// K_CONST is round(2^(PINC_W+K_FRAC) / FS_HZ): Hz times K_CONST, shifted down by K_FRAC, gives phase_inc.
package tune_pkg;

  localparam int FS_HZ   = 16_000_000;
  localparam int FREQ_W  = 24;
  localparam int PINC_W  = 27;
  localparam int K_FRAC  = 20;
  localparam int K_W     = 24;
  localparam int PROD_W  = FREQ_W + K_W;
  localparam int ARITH_W = FREQ_W + 2;

  localparam int F_MIN  = 100_000;
  localparam int F_MAX  = 7_999_999;
  localparam int F_INIT = 1_000_000;

  localparam logic [K_W-1:0]    K_CONST   = 24'd8_796_093;
  localparam logic [PROD_W-1:0] ROUND_ADD = PROD_W'(1) << (K_FRAC - 1);

  localparam logic signed [3:0] PEND_MAX = 4'sd7;
  localparam logic signed [3:0] PEND_MIN = -4'sd7;

  localparam logic signed [ARITH_W-1:0] F_MIN_S = ARITH_W'(F_MIN);
  localparam logic signed [ARITH_W-1:0] F_MAX_S = ARITH_W'(F_MAX);

  typedef enum logic [1:0] {INIT, IDLE, MULT, DONE} state_e;

  // Hz per detent for each step_sel code.
  function automatic logic [13:0] step_hz(input logic [1:0] sel);
    case (sel)
      2'd0:    step_hz = 14'd10;
      2'd1:    step_hz = 14'd100;
      2'd2:    step_hz = 14'd1000;
      default: step_hz = 14'd10000;
    endcase
  endfunction

  // Pin a signed candidate frequency into the legal band; never wraps.
  function automatic logic [FREQ_W-1:0] clamp_freq(input logic signed [ARITH_W-1:0] x);
    if (x < F_MIN_S)
      clamp_freq = FREQ_W'(F_MIN);
    else if (x > F_MAX_S)
      clamp_freq = FREQ_W'(F_MAX);
    else
      clamp_freq = FREQ_W'(x);
  endfunction

endpackage

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential unsigned multiplier, one bit of 'a' per cycle.
// A start pulse loads the operands; done pulses for one cycle once product is final (A_W cycles later).
module shift_add_mult #(
  parameter int A_W = 24,
  parameter int B_W = 24
) (
  input  logic               aclk,
  input  logic               reset,
  input  logic               start,
  input  logic [A_W-1:0]     a,
  input  logic [B_W-1:0]     b,
  output logic               busy,
  output logic               done,
  output logic [A_W+B_W-1:0] product
);

  localparam int P_W   = A_W + B_W;
  localparam int CNT_W = $clog2(A_W + 1);

  logic [A_W-1:0]   a_q, a_d;
  logic [P_W-1:0]   b_q, b_d;
  logic [P_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Consume the lowest multiplicand bit each cycle, adding the shifted multiplier when it is set.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      a_d    = a;
      b_d    = P_W'(b);
      acc_d  = '0;
      cnt_d  = CNT_W'(A_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (a_q[0])
        acc_d = acc_q + b_q;
      a_d   = a_q >> 1;
      b_d   = b_q << 1;
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  // Multiplier state registers; reset abandons any multiply in flight.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/tune_sequencer.sv
// tune_sequencer: owns the tuning frequency, merges encoder detents and UART sets,
// converts Hz to an NCO phase increment and publishes it with a one-cycle valid pulse.
// Build option TUNE_ROUND_EN: round the conversion to nearest instead of truncating.
module tune_sequencer
  import tune_pkg::*;
(
  input  logic              aclk,
  input  logic              reset,
  input  logic              enc_step,
  input  logic              enc_dir,
  input  logic [1:0]        step_sel,
  input  logic              set_valid,
  input  logic [FREQ_W-1:0] set_freq,
  output logic              set_ready,
  output logic [FREQ_W-1:0] freq,
  output logic              busy,
  output logic [PINC_W-1:0] phase_inc,
  output logic              phase_inc_valid
);

  state_e                     state_q, state_d;
  logic [FREQ_W-1:0]          freq_q, freq_d;
  logic signed [3:0]          pend_q, pend_d;
  logic signed [3:0]          pend_base;
  logic [PINC_W-1:0]          phase_inc_q, phase_inc_d;
  logic                       valid_q, valid_d;
  logic                       set_ready_q, set_ready_d;
  logic                       busy_q, busy_d;
  logic                       consume;
  logic                       mult_start, mult_busy, mult_done;
  logic [PROD_W-1:0]          mult_product, product_adj;
  logic signed [ARITH_W-1:0]  pend_ext, step_ext, stepped_freq, set_ext;

  shift_add_mult #(
    .A_W(FREQ_W),
    .B_W(K_W)
  ) u_mult (
    .aclk   (aclk),
    .reset  (reset),
    .start  (mult_start),
    .a      (freq_d),
    .b      (K_CONST),
    .busy   (mult_busy),
    .done   (mult_done),
    .product(mult_product)
  );

`ifdef TUNE_ROUND_EN
  assign product_adj = mult_product + ROUND_ADD;
`else
  assign product_adj = mult_product;
`endif

  // Candidate frequencies in signed arithmetic wide enough that under/overflow is visible to the clamp.
  always_comb begin
    pend_ext     = ARITH_W'(pend_q);
    step_ext     = ARITH_W'(step_hz(step_sel));
    stepped_freq = $signed({2'b00, freq_q}) + pend_ext * step_ext;
    set_ext      = $signed({2'b00, set_freq});
  end

  // Sequencer: accept a set or pending detents in IDLE, wait for the multiply, publish the result.
  always_comb begin
    state_d     = state_q;
    freq_d      = freq_q;
    phase_inc_d = phase_inc_q;
    valid_d     = 1'b0;
    consume     = 1'b0;
    mult_start  = 1'b0;
    case (state_q)
      INIT: begin
        mult_start = 1'b1;
        state_d    = MULT;
      end
      IDLE: begin
        if (set_valid) begin
          freq_d     = clamp_freq(set_ext);
          consume    = 1'b1;
          mult_start = 1'b1;
          state_d    = MULT;
        end else if (pend_q != 4'sd0) begin
          freq_d     = clamp_freq(stepped_freq);
          consume    = 1'b1;
          mult_start = 1'b1;
          state_d    = MULT;
        end
      end
      MULT: begin
        if (mult_done && !mult_busy) begin
          phase_inc_d = PINC_W'(product_adj >> K_FRAC);
          valid_d     = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = INIT;
      end
    endcase
    busy_d      = (state_d != IDLE);
    set_ready_d = (state_d == IDLE);
  end

  // Detent accumulator: a consume clears it but a detent arriving in the same cycle is kept.
  always_comb begin
    pend_base = consume ? 4'sd0 : pend_q;
    pend_d    = pend_base;
    if (enc_step) begin
      if (enc_dir && (pend_base != PEND_MAX))
        pend_d = pend_base + 4'sd1;
      else if (!enc_dir && (pend_base != PEND_MIN))
        pend_d = pend_base - 4'sd1;
    end
  end

  // State and registered outputs; reset restarts from INIT so F_INIT is republished.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      freq_q      <= FREQ_W'(F_INIT);
      pend_q      <= 4'sd0;
      phase_inc_q <= '0;
      valid_q     <= 1'b0;
      set_ready_q <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      freq_q      <= freq_d;
      pend_q      <= pend_d;
      phase_inc_q <= phase_inc_d;
      valid_q     <= valid_d;
      set_ready_q <= set_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign set_ready       = set_ready_q;
  assign freq            = freq_q;
  assign busy            = busy_q;
  assign phase_inc       = phase_inc_q;
  assign phase_inc_valid = valid_q;

endmodule

// File: tb/tb_tune_sequencer.sv
// tb_tune_sequencer: scoreboard bench for tune_sequencer.
// Expected frequencies are queued as stimulus is driven; each phase_inc_valid pulse pops one
// and checks both freq and phase_inc against an independent Hz-to-increment model.
module tb_tune_sequencer;

  localparam longint FS      = 16_000_000;
  localparam longint K_MODEL = ((64'sd1 <<< 47) + (FS / 2)) / FS;
  localparam longint LO      = 100_000;
  localparam longint HI      = 7_999_999;
  localparam longint FINIT   = 1_000_000;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        enc_step = 1'b0;
  logic        enc_dir = 1'b0;
  logic [1:0]  step_sel = 2'd0;
  logic        set_valid = 1'b0;
  logic [23:0] set_freq = 24'd0;
  logic        set_ready;
  logic [23:0] freq;
  logic        busy;
  logic [26:0] phase_inc;
  logic        phase_inc_valid;

  int     total = 0;
  int     bad = 0;
  int     valid_seen = 0;
  longint exp_q[$];
  longint mon_f;

  tune_sequencer dut (
    .aclk           (aclk),
    .reset          (reset),
    .enc_step       (enc_step),
    .enc_dir        (enc_dir),
    .step_sel       (step_sel),
    .set_valid      (set_valid),
    .set_freq       (set_freq),
    .set_ready      (set_ready),
    .freq           (freq),
    .busy           (busy),
    .phase_inc      (phase_inc),
    .phase_inc_valid(phase_inc_valid)
  );

  always #5 aclk = ~aclk;

  function automatic longint model_clamp(input longint x);
    if (x < LO) return LO;
    if (x > HI) return HI;
    return x;
  endfunction

  function automatic logic [26:0] model_pinc(input longint f);
    longint p;
    p = f * K_MODEL;
`ifdef TUNE_ROUND_EN
    p = p + (longint'(1) <<< 19);
`endif
    return 27'(p >>> 20);
  endfunction

  // Scoreboard: every valid pulse must match the oldest outstanding expectation.
  always @(negedge aclk) begin
    if (phase_inc_valid === 1'b1) begin
      valid_seen++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_valid phase_inc=%0d freq=%0d", phase_inc, freq);
      end else begin
        mon_f = exp_q.pop_front();
        total++;
        if (freq !== 24'(mon_f)) begin
          bad++;
          $display("[TB] FAIL sb_freq got=%0d exp=%0d", freq, mon_f);
        end
        total++;
        if (phase_inc !== model_pinc(mon_f)) begin
          bad++;
          $display("[TB] FAIL sb_phase_inc got=%0d exp=%0d (freq %0d)", phase_inc, model_pinc(mon_f), mon_f);
        end
      end
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 100 && set_ready !== 1'b1; i++) tick();
    if (set_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_ready_timeout got=%b exp=1", tag, set_ready);
    end
  endtask

  task automatic do_set(input longint f);
    wait_ready("set");
    set_valid = 1'b1;
    set_freq  = 24'(f);
    exp_q.push_back(model_clamp(f));
    tick();
    set_valid = 1'b0;
  endtask

  task automatic pulse(input logic dir);
    enc_step = 1'b1;
    enc_dir  = dir;
    tick();
    enc_step = 1'b0;
  endtask

  task automatic drain(input string tag);
    int i;
    i = 0;
    while (i < 300 && !(exp_q.size() == 0 && set_ready === 1'b1)) begin
      tick();
      i++;
    end
    total++;
    if (!(exp_q.size() == 0 && set_ready === 1'b1)) begin
      bad++;
      $display("[TB] FAIL %s_drain_timeout outstanding=%0d exp=0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_latency(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (phase_inc_valid !== 1'b1 && n < 60);
    total++;
    if (n != 26 || phase_inc_valid !== 1'b1) begin
      bad++;
      $display("[TB] FAIL %s_latency got=%0d exp=26", tag, n);
    end
  endtask

  task automatic check_freq(input string tag, input longint f);
    total++;
    if (freq !== 24'(f)) begin
      bad++;
      $display("[TB] FAIL %s_freq got=%0d exp=%0d", tag, freq, f);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_freq(tag, FINIT);
    total++;
    if (phase_inc !== 27'd0) begin bad++; $display("[TB] FAIL %s_phase_inc got=%0d exp=0", tag, phase_inc); end
    total++;
    if (phase_inc_valid !== 1'b0) begin bad++; $display("[TB] FAIL %s_valid got=%b exp=0", tag, phase_inc_valid); end
    total++;
    if (set_ready !== 1'b0) begin bad++; $display("[TB] FAIL %s_set_ready got=%b exp=0", tag, set_ready); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL %s_busy got=%b exp=1", tag, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    check_reset_values("reset");
    exp_q.push_back(FINIT);
    reset = 1'b0;
    check_latency("init");
    drain("init");
    repeat (5) tick();
    total++;
    if (valid_seen != 1) begin
      bad++;
      $display("[TB] FAIL init_pulse_count got=%0d exp=1", valid_seen);
    end
  endtask

  task automatic test_enc_steps();
    step_sel = 2'd2;
    exp_q.push_back(1_001_000);
    exp_q.push_back(1_003_000);
    pulse(1'b1);
    pulse(1'b1);
    pulse(1'b1);
    drain("enc");
    check_freq("enc", 1_003_000);
  endtask

  task automatic test_clamp();
    do_set(7_999_000);
    drain("set_hi");
    step_sel = 2'd3;
    exp_q.push_back(model_clamp(7_999_000 + 10_000));
    pulse(1'b1);
    drain("step_hi");
    check_freq("clamp_hi", HI);
    do_set(9_000_000);
    drain("set_over");
    do_set(50_000);
    drain("set_under");
    step_sel = 2'd0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(LO);
      pulse(1'b0);
      drain("step_lo");
    end
    check_freq("clamp_lo", LO);
    do_set(LO);
    drain("same_freq");
  endtask

  task automatic test_set_and_step();
    bit hit;
    hit = 1'b0;
    do_set(1_500_000);
    step_sel = 2'd2;
    pulse(1'b0);
    pulse(1'b0);
    set_valid = 1'b1;
    set_freq  = 24'd2_000_000;
    exp_q.push_back(2_000_000);
    exp_q.push_back(2_001_000);
    tick();
    total++;
    if (set_ready !== 1'b0) begin bad++; $display("[TB] FAIL busy_set_ready got=%b exp=0", set_ready); end
    check_freq("held_set", 1_500_000);
    for (int i = 0; i < 100 && !hit; i++) begin
      if (set_ready === 1'b1) begin
        enc_step = 1'b1;
        enc_dir  = 1'b1;
        tick();
        enc_step  = 1'b0;
        set_valid = 1'b0;
        hit = 1'b1;
      end else begin
        tick();
      end
    end
    set_valid = 1'b0;
    total++;
    if (!hit) begin bad++; $display("[TB] FAIL held_set_accept got=0 exp=1"); end
    drain("set_step");
    check_freq("set_step", 2_001_000);
  endtask

  task automatic test_saturation();
    do_set(3_000_000);
    step_sel = 2'd3;
    repeat (10) pulse(1'b1);
    step_sel = 2'd1;
    exp_q.push_back(3_000_700);
    drain("sat");
    check_freq("sat", 3_000_700);
  endtask

  task automatic test_reset_mid_mult();
    do_set(4_000_000);
    repeat (9) tick();
    reset = 1'b1;
    exp_q.delete();
    #1;
    check_reset_values("mid_reset");
    tick();
    tick();
    exp_q.push_back(FINIT);
    reset = 1'b0;
    check_latency("reinit");
    drain("reinit");
  endtask

  initial begin
    test_reset();
    test_enc_steps();
    test_clamp();
    test_set_and_step();
    test_saturation();
    test_reset_mid_mult();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL leftover_expect got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
